tap_period_meter: RTL and testbench
===================================

Name: tap_period_meter

Overview:
- Consumes the periodic one-cycle tick from the time-pulse generator and the debounced tap button.
- Measures the number of ticks between two consecutive rising edges of the button.
- Presents each measurement on a valid/ready output toward the BPM computation stage.
- Acts as the receiving end of the tick stream: it counts pulses instead of producing them.

Parameters:
- PERIOD_WIDTH, 16: width of the tick counter and of period_o.
- MIN_PERIOD, 2: measurements below this tick count are treated as bounce and ignored.
- MAX_PERIOD, 2**PERIOD_WIDTH-1: tick count at which a measurement is abandoned (timeout). Must satisfy MIN_PERIOD < MAX_PERIOD <= 2**PERIOD_WIDTH-1.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- tp_i, in, 1: time-pulse tick, one clk_i cycle wide, synchronous to clk_i.
- btn_i, in, 1: debounced tap button level, synchronous to clk_i.
- period_o, out, PERIOD_WIDTH: last measured tick count.
- period_valid_o, out, 1: period_o holds an unconsumed measurement.
- period_ready_i, in, 1: downstream accepts period_o.
- timeout_o, out, 1: one-cycle pulse when a measurement is abandoned at MAX_PERIOD.
- overrun_o, out, 1: one-cycle pulse when an unconsumed measurement is overwritten.

Behaviour:
- Reset (async, rst_i high): state=IDLE, counter=0, btn_q=0, period_o=0, period_valid_o=0, timeout_o=0, overrun_o=0. Reset mid-measurement discards everything, including a pending period.
- Edge detection:
  - btn_q is the registered btn_i.
  - rise = btn_i & ~btn_q (combinational).
  - btn_i already high at reset release produces a rise on the first clock.
- eff = counter + tp_i. This is the count including a tick in the current cycle. Width is PERIOD_WIDTH; it cannot overflow because counter <= MAX_PERIOD-1 in COUNT.
- State IDLE:
  - rise -> COUNT, counter<=0. A tick in the same cycle is not counted.
  - Otherwise stay; counter holds 0.
- State COUNT, priority order:
  1. rise with eff >= MIN_PERIOD: publish eff, counter<=0, stay COUNT.
  2. rise with eff < MIN_PERIOD: bounce. counter<=eff, no publish, stay COUNT.
  3. No rise, tp_i=1, counter==MAX_PERIOD-1: timeout. counter<=0, state<=IDLE, timeout_o=1 for the next cycle, no publish.
  4. No rise, tp_i=1: counter<=counter+1.
  5. Otherwise: hold.
- Rise and timeout in the same cycle: the rise wins. It publishes MAX_PERIOD and stays in COUNT.
- Publish, registered: period_o<=eff and period_valid_o<=1, both visible the cycle after the rise.
- Output handshake:
  - Transfer occurs when period_valid_o & period_ready_i.
  - Transfer without a publish in the same cycle: period_valid_o<=0 next cycle.
  - Publish while period_valid_o=1 and period_ready_i=1: the old value transfers, the new value loads, valid stays 1, no overrun.
  - Publish while period_valid_o=1 and period_ready_i=0: the new value overwrites and overrun_o=1 for one cycle.
  - period_o is stable while valid=1 and ready=0, except on overwrite.
  - period_o holds its last value after valid drops.
- timeout_o and overrun_o are registered single-cycle pulses and are never asserted for two consecutive cycles by one event.
- Latency: rise at cycle N -> period_valid_o high at N+1.

Decomposition:
- Shared package tap_pkg:
  - State encoding localparams (ST_IDLE=0, ST_COUNT=1).
  - Default PERIOD_WIDTH constant, shared with the BPM stage.
- Natural sub-module: rise_edge_det (btn_q register plus rise output). It is reusable by the debouncer path. Everything else stays in one module.

Test Plan:
- Basic measurement (MIN=2): rise, then 10 ticks, then rise, with ready held 1 -> period_o=10, period_valid_o=1 for exactly 1 cycle, the cycle after the second rise.
- Same-cycle tick: second rise coincides with the 5th tick -> period_o=5.
- Bounce filter (MIN_PERIOD=4): rise, 2 ticks, rise, 3 ticks, rise -> no publish at the 2nd rise; publish 5 at the 3rd rise.
- Timeout (PERIOD_WIDTH=4, MAX=15): rise, then 15 ticks with no rise -> timeout_o pulse one cycle after the 15th tick, state IDLE, no valid. A following rise restarts the count from 0.
- Backpressure and overrun (ready=0): two back-to-back measurements of 6 and then 7 -> period_o=7, overrun_o=1 for one cycle, valid stays 1. Raising ready -> valid drops the next cycle.
- Async reset mid-count: assert rst_i between clock edges after 3 ticks -> all outputs 0 immediately. After release, the next rise plus 4 ticks plus rise -> period_o=4.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared types and constants for the tap tempo path.
// Used by the period meter and the BPM stage.
package tap_pkg;

  localparam int TAP_PERIOD_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } tap_state_e;

endpackage

// File: rtl/rise_edge_det.sv
// Registered level plus combinational rising-edge flag.
// Shared by the tap meter and the debouncer path.
module rise_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic d_q;

  // previous-cycle copy of the level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign q_o    = d_q;
  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/tap_period_meter.sv
// Counts tp_i ticks between consecutive button rises
// and offers each count on a valid/ready output.
module tap_period_meter
  import tap_pkg::*;
#(
  parameter int PERIOD_WIDTH = TAP_PERIOD_WIDTH,
  parameter int MIN_PERIOD   = 2,
  parameter int MAX_PERIOD   = 2**PERIOD_WIDTH-1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tp_i,
  input  logic                    btn_i,
  output logic [PERIOD_WIDTH-1:0] period_o,
  output logic                    period_valid_o,
  input  logic                    period_ready_i,
  output logic                    timeout_o,
  output logic                    overrun_o
);

  localparam logic [PERIOD_WIDTH-1:0] MinP =
    PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] LastP =
    PERIOD_WIDTH'(MAX_PERIOD - 1);

  tap_state_e              state_q;
  logic [PERIOD_WIDTH-1:0] cnt_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    valid_q;
  logic                    timeout_q;
  logic                    overrun_q;

  logic                    btn_q;
  logic                    rise;
  logic [PERIOD_WIDTH-1:0] eff;
  logic                    xfer;

  rise_edge_det u_rise (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (btn_i),
    .q_o    (btn_q),
    .rise_o (rise)
  );

  // count including a tick arriving this cycle;
  // cnt_q never exceeds MAX-1 so this cannot wrap
  assign eff  = cnt_q + PERIOD_WIDTH'(tp_i);
  assign xfer = valid_q & period_ready_i;

  // measurement FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      if (xfer) valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (rise) state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          if (rise && eff >= MinP) begin
            period_q  <= eff;
            valid_q   <= 1'b1;
            overrun_q <= valid_q & ~period_ready_i;
            cnt_q     <= '0;
          end else if (rise) begin
            cnt_q <= eff;
          end else if (tp_i && cnt_q == LastP) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else if (tp_i) begin
            cnt_q <= cnt_q + PERIOD_WIDTH'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = valid_q;
  assign timeout_o      = timeout_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_tap_period_meter.sv
// Directed bench for tap_period_meter.
// Three instances cover MIN=2, MIN=4 and a 4-bit timeout build.
module tb_tap_period_meter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic tp_i = 1'b0;
  logic btn_i = 1'b0;
  logic ready_i = 1'b1;

  logic [15:0] pa, pb;
  logic [3:0]  pc;
  logic va, vb, vc, ta, tb, tc, oa, ob, oc;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  tap_period_meter #(.PERIOD_WIDTH(16), .MIN_PERIOD(2)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .btn_i(btn_i),
    .period_o(pa), .period_valid_o(va), .period_ready_i(ready_i),
    .timeout_o(ta), .overrun_o(oa)
  );

  tap_period_meter #(.PERIOD_WIDTH(16), .MIN_PERIOD(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .btn_i(btn_i),
    .period_o(pb), .period_valid_o(vb), .period_ready_i(ready_i),
    .timeout_o(tb), .overrun_o(ob)
  );

  tap_period_meter #(
    .PERIOD_WIDTH(4), .MIN_PERIOD(2), .MAX_PERIOD(15)
  ) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .tp_i(tp_i), .btn_i(btn_i),
    .period_o(pc), .period_valid_o(vc), .period_ready_i(ready_i),
    .timeout_o(tc), .overrun_o(oc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic tp, input logic b);
    tp_i  = tp;
    btn_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    tp_i    = 1'b0;
    btn_i   = 1'b0;
    ready_i = 1'b1;
    rst_i   = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_period", 32'(pa), 0);
    chk("rst_valid", 32'(va), 0);
    chk("rst_timeout", 32'(ta), 0);
    chk("rst_overrun", 32'(oa), 0);

    // basic measurement of 10
    cyc(1'b0, 1'b1);
    ticks(10);
    chk("basic_pre_valid", 32'(va), 0);
    cyc(1'b0, 1'b1);
    chk("basic_valid", 32'(va), 1);
    chk("basic_period", 32'(pa), 10);
    cyc(1'b0, 1'b0);
    chk("basic_valid_drop", 32'(va), 0);
    chk("basic_period_hold", 32'(pa), 10);

    // tick coincides with the closing rise
    ticks(4);
    cyc(1'b1, 1'b1);
    chk("same_cyc_valid", 32'(va), 1);
    chk("same_cyc_period", 32'(pa), 5);

    // bounce filter with MIN=4
    do_reset();
    cyc(1'b0, 1'b1);
    ticks(2);
    cyc(1'b0, 1'b1);
    chk("bounce_no_valid", 32'(vb), 0);
    ticks(3);
    cyc(1'b0, 1'b1);
    chk("bounce_valid", 32'(vb), 1);
    chk("bounce_period", 32'(pb), 5);

    // timeout at 15 ticks on the 4-bit build
    do_reset();
    cyc(1'b0, 1'b1);
    ticks(14);
    chk("to_early", 32'(tc), 0);
    ticks(1);
    chk("to_pulse", 32'(tc), 1);
    chk("to_no_valid", 32'(vc), 0);
    cyc(1'b1, 1'b0);
    chk("to_pulse_end", 32'(tc), 0);
    cyc(1'b0, 1'b1);
    ticks(3);
    cyc(1'b0, 1'b1);
    chk("to_restart_valid", 32'(vc), 1);
    chk("to_restart_period", 32'(pc), 3);

    // rise and timeout together: rise wins
    cyc(1'b0, 1'b0);
    ticks(14);
    cyc(1'b1, 1'b1);
    chk("to_rise_period", 32'(pc), 15);
    chk("to_rise_valid", 32'(vc), 1);
    chk("to_rise_no_to", 32'(tc), 0);

    // backpressure and overrun
    do_reset();
    ready_i = 1'b0;
    cyc(1'b0, 1'b1);
    ticks(6);
    cyc(1'b0, 1'b1);
    chk("bp_period6", 32'(pa), 6);
    chk("bp_valid6", 32'(va), 1);
    chk("bp_no_ovr", 32'(oa), 0);
    ticks(7);
    chk("bp_stable", 32'(pa), 6);
    chk("bp_stable_v", 32'(va), 1);
    cyc(1'b0, 1'b1);
    chk("bp_period7", 32'(pa), 7);
    chk("bp_ovr", 32'(oa), 1);
    chk("bp_valid7", 32'(va), 1);
    cyc(1'b0, 1'b0);
    chk("bp_ovr_end", 32'(oa), 0);
    chk("bp_valid_held", 32'(va), 1);
    ready_i = 1'b1;
    cyc(1'b0, 1'b0);
    chk("bp_valid_drop", 32'(va), 0);
    chk("bp_period_hold", 32'(pa), 7);

    // async reset mid-count with a pending result
    ready_i = 1'b0;
    ticks(2);
    cyc(1'b0, 1'b1);
    chk("ar_pending", 32'(va), 1);
    ticks(3);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_period", 32'(pa), 0);
    chk("ar_valid", 32'(va), 0);
    #1 rst_i = 1'b0;
    ready_i = 1'b1;
    cyc(1'b0, 1'b1);
    ticks(4);
    cyc(1'b0, 1'b1);
    chk("ar_after_valid", 32'(va), 1);
    chk("ar_after_period", 32'(pa), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
